// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot ring counter plus opcode decode
// producing the 12-bit W-bus control word, with run/step/halt sequencing.
module sap1_controller (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        run,
  input  logic        step,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic [5:0]  tstate,
  output logic        halted,
  output logic        instr_done
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e     state_r;
  tstate_e     state_next_s;
  logic        halted_r;
  logic        halted_next_s;
  logic        done_r;
  logic        done_next_s;
  logic        en_s;
  logic [11:0] con_s;

  // Fetch words are opcode-independent; execute words keep alu_sub up over T5/T6.
  function automatic logic [11:0] decode(input tstate_e t, input logic [3:0] op);
    logic [11:0] cw;
    cw = 12'h000;
    case (t)
      T1: cw = 12'h600;
      T2: cw = 12'h800;
      T3: cw = 12'h180;
      T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: cw = 12'h240;
          OP_OUT:                 cw = 12'h011;
          default:                cw = 12'h000;
        endcase
      end
      T5: begin
        case (op)
          OP_LDA:  cw = 12'h120;
          OP_ADD:  cw = 12'h102;
          OP_SUB:  cw = 12'h10A;
          default: cw = 12'h000;
        endcase
      end
      T6: begin
        case (op)
          OP_ADD:  cw = 12'h024;
          OP_SUB:  cw = 12'h02C;
          default: cw = 12'h000;
        endcase
      end
      default: cw = 12'h000;
    endcase
    return cw;
  endfunction

  assign en_s = (run | step) & ~halted_r;

  // Ring advance, HLT capture and end-of-instruction pulse
  always_comb begin
    state_next_s  = state_r;
    halted_next_s = halted_r;
    done_next_s   = 1'b0;
    if (en_s) begin
      if ((state_r == T4) && (opcode == OP_HLT)) begin
        halted_next_s = 1'b1;
      end else begin
        done_next_s = (state_r == T6);
        case (state_r)
          T1:      state_next_s = T2;
          T2:      state_next_s = T3;
          T3:      state_next_s = T4;
          T4:      state_next_s = T5;
          T5:      state_next_s = T6;
          T6:      state_next_s = T1;
          default: state_next_s = T1;
        endcase
      end
    end else begin
      state_next_s  = state_r;
      halted_next_s = halted_r;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r  <= T1;
      halted_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= halted_next_s;
      done_r   <= done_next_s;
    end
  end

  // Held T-states emit nothing so side effects such as pc_inc never repeat
  always_comb begin
    con_s = 12'h000;
    if (clr_n && en_s) begin
      con_s = decode(state_r, opcode);
    end else begin
      con_s = 12'h000;
    end
  end

  assign con        = con_s;
  assign tstate     = state_r;
  assign halted     = halted_r;
  assign instr_done = done_r;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed and randomized checks of sap1_controller, including a small SAP-1
// datapath model driven by the control word for the full-program scenario.
module tb_sap1_controller;

  logic        clk;
  logic        clr_n;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  tstate;
  logic        halted;
  logic        instr_done;

  logic [3:0]  op_drv;
  logic        use_dp;
  int          errors;
  int          checks;

  logic [7:0]  mem [16];
  logic [3:0]  pc_m;
  logic [3:0]  mar_m;
  logic [7:0]  ir_m;
  logic [7:0]  a_m;
  logic [7:0]  b_m;
  logic [7:0]  out_m;
  logic [7:0]  bus_s;

  logic [11:0] exp_lda [6];
  logic [3:0]  ops [6];

  sap1_controller dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .run        (run),
    .step       (step),
    .opcode     (opcode),
    .con        (con),
    .tstate     (tstate),
    .halted     (halted),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign opcode = use_dp ? ir_m[7:4] : op_drv;

  // W-bus: OR of every enabled driver
  always @* begin
    bus_s = 8'h00;
    if (con[10]) bus_s = bus_s | {4'h0, pc_m};
    if (con[8])  bus_s = bus_s | mem[mar_m];
    if (con[6])  bus_s = bus_s | {4'h0, ir_m[3:0]};
    if (con[4])  bus_s = bus_s | a_m;
    if (con[2])  bus_s = bus_s | (con[3] ? (a_m - b_m) : (a_m + b_m));
  end

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc_m <= 4'h0; mar_m <= 4'h0; ir_m <= 8'h00;
      a_m <= 8'h00; b_m <= 8'h00; out_m <= 8'h00;
    end else begin
      if (con[11]) pc_m <= pc_m + 4'h1;
      if (con[9])  mar_m <= bus_s[3:0];
      if (con[7])  ir_m <= bus_s;
      if (con[5])  a_m <= bus_s;
      if (con[1])  b_m <= bus_s;
      if (con[0])  out_m <= bus_s;
    end
  end

  task automatic do_reset();
    clr_n = 1'b0; run = 1'b0; step = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (tstate !== 6'b000001) begin errors++; $display("FAIL reset_tstate got=%b exp=%b", tstate, 6'b000001); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", instr_done); end
    run = 1'b1; step = 1'b1; op_drv = 4'h0; #1;
    checks++; if (con !== 12'h000) begin errors++; $display("FAIL reset_con got=%h exp=000", con); end
    run = 1'b0; step = 1'b0;
  endtask

  task automatic test_lda_run();
    do_reset();
    op_drv = 4'h0; clr_n = 1'b1; run = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++; if (con !== exp_lda[i]) begin errors++; $display("FAIL lda_con t%0d got=%h exp=%h", i + 1, con, exp_lda[i]); end
      checks++; if (tstate !== (6'b000001 << i)) begin errors++; $display("FAIL lda_tstate t%0d got=%b exp=%b", i + 1, tstate, 6'b000001 << i); end
    end
    @(negedge clk); #1;
    checks++; if (tstate !== 6'b000001) begin errors++; $display("FAIL lda_wrap got=%b exp=000001", tstate); end
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL lda_done got=%b exp=1", instr_done); end
    checks++; if (con !== 12'h600) begin errors++; $display("FAIL lda_refetch got=%h exp=600", con); end
    @(negedge clk); #1;
    checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL lda_done_pulse got=%b exp=0", instr_done); end
    run = 1'b0;
  endtask

  task automatic test_nop();
    do_reset();
    op_drv = 4'b0101; clr_n = 1'b1; run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 3; i < 6; i++) begin
      if (i > 3) begin @(negedge clk); #1; end
      checks++; if (con !== 12'h000) begin errors++; $display("FAIL nop_con t%0d got=%h exp=000", i + 1, con); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL nop_halted t%0d got=%b exp=0", i + 1, halted); end
    end
    @(negedge clk); #1;
    checks++; if (tstate !== 6'b000001) begin errors++; $display("FAIL nop_wrap got=%b exp=000001", tstate); end
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL nop_done got=%b exp=1", instr_done); end
    run = 1'b0;
  endtask

  task automatic test_step();
    int pc_pulses;
    int idx;
    pc_pulses = 0;
    do_reset();
    op_drv = 4'h0; clr_n = 1'b1;
    for (int p = 0; p < 12; p++) begin
      idx = p % 6;
      step = 1'b1; #1;
      checks++; if (con !== exp_lda[idx]) begin errors++; $display("FAIL step_con p%0d got=%h exp=%h", p, con, exp_lda[idx]); end
      checks++; if (tstate !== (6'b000001 << idx)) begin errors++; $display("FAIL step_tstate p%0d got=%b exp=%b", p, tstate, 6'b000001 << idx); end
      if (con[11]) pc_pulses++;
      @(negedge clk);
      step = 1'b0; #1;
      checks++; if (tstate !== (6'b000001 << ((idx + 1) % 6))) begin errors++; $display("FAIL step_adv p%0d got=%b exp=%b", p, tstate, 6'b000001 << ((idx + 1) % 6)); end
      checks++; if (instr_done !== (idx == 5)) begin errors++; $display("FAIL step_done p%0d got=%b exp=%b", p, instr_done, idx == 5); end
      repeat (3) begin
        checks++; if (con !== 12'h000) begin errors++; $display("FAIL step_idle_con p%0d got=%h exp=000", p, con); end
        if (con[11]) pc_pulses++;
        @(negedge clk); #1;
      end
      checks++; if (tstate !== (6'b000001 << ((idx + 1) % 6))) begin errors++; $display("FAIL step_hold p%0d got=%b exp=%b", p, tstate, 6'b000001 << ((idx + 1) % 6)); end
    end
    checks++; if (pc_pulses !== 2) begin errors++; $display("FAIL step_pc_inc got=%0d exp=2", pc_pulses); end
  endtask

  task automatic test_run_and_step();
    do_reset();
    op_drv = 4'h0; clr_n = 1'b1; run = 1'b1; step = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      checks++; if (tstate !== (6'b000001 << (i % 6))) begin errors++; $display("FAIL both_tstate c%0d got=%b exp=%b", i, tstate, 6'b000001 << (i % 6)); end
    end
    run = 1'b0; step = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    op_drv = 4'b0001; clr_n = 1'b1; run = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (con !== 12'h102) begin errors++; $display("FAIL mid_t5_con got=%h exp=102", con); end
    #2 clr_n = 1'b0;
    #1;
    checks++; if (tstate !== 6'b000001) begin errors++; $display("FAIL mid_tstate got=%b exp=000001", tstate); end
    checks++; if (con !== 12'h000) begin errors++; $display("FAIL mid_con got=%h exp=000", con); end
    @(negedge clk);
    clr_n = 1'b1; #1;
    checks++; if (con !== 12'h600) begin errors++; $display("FAIL mid_restart got=%h exp=600", con); end
    run = 1'b0;
  endtask

  task automatic test_system();
    int cyc;
    do_reset();
    use_dp = 1'b1; clr_n = 1'b1; run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sys_halted got=%b exp=1 (timeout)", halted); end
    checks++; if (cyc !== 28) begin errors++; $display("FAIL sys_halt_cycle got=%0d exp=28", cyc); end
    checks++; if (out_m !== 8'd7) begin errors++; $display("FAIL sys_out got=%0d exp=7", out_m); end
    checks++; if (pc_m !== 4'd5) begin errors++; $display("FAIL sys_pc got=%0d exp=5", pc_m); end
    for (int i = 0; i < 20; i++) begin
      step = i[0];
      @(negedge clk); #1;
      checks++; if (con !== 12'h000) begin errors++; $display("FAIL sys_hold_con c%0d got=%h exp=000", i, con); end
      checks++; if (tstate !== 6'b001000) begin errors++; $display("FAIL sys_hold_tstate c%0d got=%b exp=001000", i, tstate); end
      checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL sys_hold_done c%0d got=%b exp=0", i, instr_done); end
    end
    run = 1'b0; step = 1'b0; use_dp = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    clr_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      run    = ($urandom_range(0, 99) < 40);
      step   = ($urandom_range(0, 3) == 0);
      op_drv = ops[$urandom_range(0, 5)];
      clr_n  = ($urandom_range(0, 199) != 0) && !(halted && ($urandom_range(0, 7) == 0));
      #1;
      checks++; if ($countones({con[10], con[8], con[6], con[4], con[2]}) > 1) begin errors++; $display("FAIL rnd_bus c%0d con=%h", c, con); end
      checks++; if (!$onehot(tstate)) begin errors++; $display("FAIL rnd_onehot c%0d got=%b", c, tstate); end
    end
    clr_n = 1'b1; run = 1'b0; step = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    clr_n = 1'b0; run = 1'b0; step = 1'b0; op_drv = 4'h0; use_dp = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h0F; mem[1] = 8'h1E; mem[2] = 8'h2D; mem[3] = 8'hE0; mem[4] = 8'hF0;
    mem[15] = 8'd5; mem[14] = 8'd3; mem[13] = 8'd1;
    exp_lda = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h5};
    test_reset();
    test_lda_run();
    test_nop();
    test_step();
    test_run_and_step();
    test_reset_mid();
    test_system();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
